// File: rtl/spi_slave_cmd_ctrl_pkg.sv
// Shared definitions for the SPI slave command/register controller:
// FSM state encoding and the fixed bit/register positions used by the top.
package spi_slave_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_WR_DATA = 2'd2,
    ST_RD_DATA = 2'd3
  } state_t;

  // Bit of the command byte that selects write (1) or read (0)
  localparam int CMD_WR_BIT  = 7;
  // Register whose low nibble drives the board LEDs
  localparam int LED_REG     = 0;
  // Bit of a LED_REG write that clears the sticky address-error flag
  localparam int ERR_CLR_BIT = 7;

endpackage

// File: rtl/spi_slave_cmd_ctrl_regfile.sv
// Small register file behind the SPI command controller: one synchronous
// write port, one combinational read port, and a hard-wired ID register in
// the top slot that ignores writes.
module spi_slave_cmd_ctrl_regfile
  import spi_slave_cmd_ctrl_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  ID_VALUE = 8'h5A
) (
  input  logic              clk_12MHz,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata,
  output logic [3:0]        o_led
);

  localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [7:0] r_regs [NUM_REGS];

  // Storage: cleared on reset, written one byte per cycle; the ID slot is never written
  always_ff @(posedge clk_12MHz or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (i_we && (i_waddr != ID_ADDR)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_raddr == ID_ADDR) ? ID_VALUE : r_regs[i_raddr];
  assign o_led   = r_regs[LED_REG][3:0];

endmodule

// File: rtl/spi_slave_cmd_ctrl.sv
// Command/register controller behind the SPI slave byte engine. The first
// byte of each CS-low frame is a command (W/R bit plus 7-bit start address);
// later bytes are written to or read from the register file with address
// auto-increment. Holds the frame FSM, address counter, TX byte mux,
// completed-frame counter and the sticky address-error flag.
module spi_slave_cmd_ctrl
  import spi_slave_cmd_ctrl_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          ADDR_W      = 4,
  parameter logic [7:0]  ID_VALUE    = 8'h5A,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic       clk_12MHz,
  input  logic       i_rst,
  input  logic       i_cs_active,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_load,
  output logic [3:0] o_led,
  output logic       o_busy,
  output logic [7:0] o_xfer_cnt,
  output logic       o_addr_err
);

  localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

  state_t     r_state;
  logic [6:0] r_addr;
  logic [7:0] r_tx_byte;
  logic       r_tx_load;
  logic [7:0] r_xfer_cnt;
  logic       r_addr_err;

  logic       w_rx_accept;
  logic [6:0] w_rd_addr;
  logic       w_rd_in_range;
  logic [7:0] w_rd_data;
  logic [7:0] w_rd_byte;
  logic       w_wr_in_range;
  logic       w_wr_is_led;
  logic       w_we;
  logic [7:0] w_wdata;

  // A byte only counts while CS is still asserted; CS dropping wins over rx_valid
  assign w_rx_accept = i_rx_valid & i_cs_active;

  // Address of the byte to present next: the command's start address, or the following one
  always_comb begin
    w_rd_addr = r_addr + 7'd1;
    if (r_state == ST_CMD) begin
      w_rd_addr = i_rx_byte[6:0];
    end
  end

  assign w_rd_in_range = ({1'b0, w_rd_addr} < NUM_REGS_L);
  assign w_rd_byte     = w_rd_in_range ? w_rd_data : FILL_BYTE;

  assign w_wr_in_range = ({1'b0, r_addr} < NUM_REGS_L);
  assign w_wr_is_led   = (r_addr == 7'(LED_REG));
  assign w_we          = (r_state == ST_WR_DATA) && w_rx_accept && w_wr_in_range;

  // The error-clear bit of the LED register is a command, so it is never stored
  always_comb begin
    w_wdata = i_rx_byte;
    if (w_wr_is_led) begin
      w_wdata[ERR_CLR_BIT] = 1'b0;
    end
  end

  spi_slave_cmd_ctrl_regfile #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk_12MHz (clk_12MHz),
    .i_rst     (i_rst),
    .i_we      (w_we),
    .i_waddr   (r_addr[ADDR_W-1:0]),
    .i_wdata   (w_wdata),
    .i_raddr   (w_rd_addr[ADDR_W-1:0]),
    .o_rdata   (w_rd_data),
    .o_led     (o_led)
  );

  // Frame FSM with registered TX byte/load, address counter, frame counter and error flag
  always_ff @(posedge clk_12MHz or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= 7'd0;
      r_tx_byte  <= STATUS_BYTE;
      r_tx_load  <= 1'b0;
      r_xfer_cnt <= 8'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_tx_load <= 1'b0;
      if (!i_cs_active) begin
        if (r_state != ST_IDLE) begin
          r_state    <= ST_IDLE;
          r_xfer_cnt <= r_xfer_cnt + 8'd1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state   <= ST_CMD;
            r_tx_byte <= STATUS_BYTE;
            r_tx_load <= 1'b1;
          end
          ST_CMD: begin
            if (i_rx_valid) begin
              r_addr <= i_rx_byte[6:0];
              if (i_rx_byte[CMD_WR_BIT]) begin
                r_state <= ST_WR_DATA;
              end else begin
                r_state   <= ST_RD_DATA;
                r_tx_byte <= w_rd_byte;
                r_tx_load <= 1'b1;
                if (!w_rd_in_range) begin
                  r_addr_err <= 1'b1;
                end
              end
            end
          end
          ST_WR_DATA: begin
            if (i_rx_valid) begin
              r_addr <= r_addr + 7'd1;
              if (!w_wr_in_range) begin
                r_addr_err <= 1'b1;
              end else if (w_wr_is_led && i_rx_byte[ERR_CLR_BIT]) begin
                r_addr_err <= 1'b0;
              end
            end
          end
          ST_RD_DATA: begin
            if (i_rx_valid) begin
              r_addr    <= r_addr + 7'd1;
              r_tx_byte <= w_rd_byte;
              r_tx_load <= 1'b1;
              if (!w_rd_in_range) begin
                r_addr_err <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_tx_byte  = r_tx_byte;
  assign o_tx_load  = r_tx_load;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_xfer_cnt = r_xfer_cnt;
  assign o_addr_err = r_addr_err;

endmodule
